// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives the data-memory bus from an M-stage
// request, extracts and extends load data, and registers the M->W boundary.
// Misaligned or out-of-range accesses never reach memory or the register
// file; they set a sticky fault flag and bump a saturating counter.
module mem_access_unit #(
  parameter int unsigned DM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_store,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_pc,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  input  logic [31:0] m_data_rdata,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr,
  output logic        fault,
  output logic [7:0]  fault_cnt
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_ALU = 4'd9;

  logic        is_load, is_store, is_alu, misaligned, out_of_range, bad;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_val;

  assign m_data_addr = m_addr;
  assign m_inst_addr = m_pc;

  assign is_load  = (m_op >= OP_LW) && (m_op <= OP_LBU);
  assign is_store = (m_op >= OP_SW) && (m_op <= OP_SB);
  assign is_alu   = (m_op == OP_ALU);
  assign out_of_range = (m_addr >= 32'(DM_BYTES));
  assign bad = m_valid && (is_load || is_store) && (misaligned || out_of_range);

  // Natural-alignment check by access width; byte ops can never misalign.
  always_comb begin
    misaligned = 1'b0;
    case (m_op)
      OP_LW, OP_SW:          misaligned = (m_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misaligned = m_addr[0];
      default:               misaligned = 1'b0;
    endcase
  end

  // Store lane steering; enables are gated off for bad, bubble or reset.
  always_comb begin
    m_data_byteen = 4'b0000;
    m_data_wdata  = m_store;
    case (m_op)
      OP_SW: m_data_byteen = 4'b1111;
      OP_SH: begin
        m_data_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
        m_data_wdata  = {2{m_store[15:0]}};
      end
      OP_SB: begin
        m_data_byteen = 4'b0001 << m_addr[1:0];
        m_data_wdata  = {4{m_store[7:0]}};
      end
      default: m_data_byteen = 4'b0000;
    endcase
    if (!reset || !m_valid || bad) m_data_byteen = 4'b0000;
  end

  // Pick the addressed half/byte out of the read word and extend it.
  always_comb begin
    rd_half = m_addr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    case (m_addr[1:0])
      2'd0:    rd_byte = m_data_rdata[7:0];
      2'd1:    rd_byte = m_data_rdata[15:8];
      2'd2:    rd_byte = m_data_rdata[23:16];
      default: rd_byte = m_data_rdata[31:24];
    endcase
    case (m_op)
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0000, rd_half};
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'h000000, rd_byte};
      default: load_val = m_data_rdata;
    endcase
  end

  // M->W register plus sticky fault flag and saturating fault counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_grf_we    <= 1'b0;
      w_grf_addr  <= 5'd0;
      w_grf_wdata <= 32'd0;
      w_inst_addr <= 32'd0;
      fault       <= 1'b0;
      fault_cnt   <= 8'd0;
    end else begin
      w_inst_addr <= m_pc;
      if (m_valid && !bad && (is_load || is_alu)) begin
        w_grf_we    <= 1'b1;
        w_grf_addr  <= m_rd;
        w_grf_wdata <= is_alu ? m_addr : load_val;
      end else begin
        w_grf_we    <= 1'b0;
        w_grf_addr  <= 5'd0;
        w_grf_wdata <= 32'd0;
      end
      if (bad) begin
        fault <= 1'b1;
        if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word-array memory model drives the read bus,
// and a behavioural model predicts bus and write-back outputs every cycle.
module tb_mem_access_unit;
  localparam int unsigned DM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        reset, m_valid;
  logic [3:0]  m_op, m_data_byteen;
  logic [31:0] m_addr, m_store, m_pc, m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
  logic [4:0]  m_rd, w_grf_addr;
  logic        w_grf_we, fault;
  logic [31:0] w_grf_wdata, w_inst_addr;
  logic [7:0]  fault_cnt;

  mem_access_unit #(.DM_BYTES(DM_BYTES)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_store(m_store), .m_rd(m_rd), .m_pc(m_pc), .m_data_addr(m_data_addr),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata), .w_grf_we(w_grf_we),
    .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr),
    .fault(fault), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic exp_fault = 1'b0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive, check M-side outputs, predict W, check W after the edge.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] s, input logic [4:0] rd, input logic [31:0] pc,
                     input logic rst);
    int size;
    logic ld, st, alu, bad;
    logic [3:0]  ebe;
    logic [31:0] ewd, word, sh, lv;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewdat, einst;
    @(negedge clk);
    reset = rst; m_valid = v; m_op = op; m_addr = a; m_store = s; m_rd = rd; m_pc = pc;
    word = mem[a[13:2]];
    m_data_rdata = word;
    #1;
    ld  = (op >= 1 && op <= 5);
    st  = (op >= 6 && op <= 8);
    alu = (op == 9);
    size = (op == 1 || op == 6) ? 4 : (op == 2 || op == 3 || op == 7) ? 2 : 1;
    bad = v && (ld || st) && ((a % size) != 0 || a >= DM_BYTES);
    ebe = 4'h0;
    ewd = s;
    if (op == 7) ewd = {s[15:0], s[15:0]};
    if (op == 8) ewd = {s[7:0], s[7:0], s[7:0], s[7:0]};
    if (rst && v && st && !bad) begin
      for (int b = 0; b < 4; b++)
        if (b >= (a % 4) - ((a % 4) % size) && b < (a % 4) - ((a % 4) % size) + size) ebe[b] = 1'b1;
    end
    chk("data_addr", m_data_addr, a);
    chk("inst_addr", m_inst_addr, pc);
    chk("byteen", 32'(m_data_byteen), 32'(ebe));
    if (ebe != 4'h0) chk("wdata", m_data_wdata, ewd);
    last_be = m_data_byteen;
    last_wd = m_data_wdata;
    // Loaded value: shift the addressed bytes down, then extend by op.
    sh = word >> (8 * (a % 4));
    case (op)
      4'd2:    lv = 32'($signed(sh[15:0]));
      4'd3:    lv = 32'(sh[15:0]);
      4'd4:    lv = 32'($signed(sh[7:0]));
      4'd5:    lv = 32'(sh[7:0]);
      default: lv = word;
    endcase
    if (!rst) begin
      ewe = 0; ewa = 0; ewdat = 0; einst = 0; exp_fault = 0; exp_cnt = 0;
    end else begin
      einst = pc;
      ewe = v && !bad && (ld || alu);
      ewa = ewe ? rd : 5'd0;
      ewdat = !ewe ? 32'd0 : alu ? a : lv;
      if (bad) begin
        exp_fault = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    for (int b = 0; b < 4; b++)
      if (ebe[b]) mem[a[13:2]][8*b +: 8] = ewd[8*b +: 8];
    @(posedge clk);
    #1;
    chk("w_we", 32'(w_grf_we), 32'(ewe));
    chk("w_addr", 32'(w_grf_addr), 32'(ewa));
    chk("w_wdata", w_grf_wdata, ewdat);
    chk("w_inst", w_inst_addr, einst);
    chk("fault", 32'(fault), 32'(exp_fault));
    chk("fault_cnt", 32'(fault_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [31:0] ra, rs, rp, rr;
    logic [3:0]  rop;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    reset = 0; m_valid = 0; m_op = 0; m_addr = 0; m_store = 0; m_rd = 0; m_pc = 0;
    m_data_rdata = 0;
    cyc(1, 4'd6, 32'h0, 32'h1, 5'd0, 32'h0, 1'b0);
    cyc(0, 4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    chk("rst_we", 32'(w_grf_we), 32'h0);
    chk("rst_wdata", w_grf_wdata, 32'h0);
    chk("rst_inst", w_inst_addr, 32'h0);
    chk("rst_cnt", 32'(fault_cnt), 32'h0);

    // Byte store/load.
    cyc(1, 4'd8, 32'h6, 32'h123456AB, 5'd1, 32'h3000, 1'b1);
    chk("sb_be_lit", 32'(last_be), 32'h4);
    chk("sb_wd_lit", last_wd, 32'hABABABAB);
    cyc(1, 4'd5, 32'h6, 32'h0, 5'd2, 32'h3004, 1'b1);
    chk("lbu_lit", w_grf_wdata, 32'h000000AB);
    cyc(1, 4'd4, 32'h6, 32'h0, 5'd2, 32'h3008, 1'b1);
    chk("lb_lit", w_grf_wdata, 32'hFFFFFFAB);
    // Half store/load.
    cyc(1, 4'd7, 32'h2, 32'h0000BEEF, 5'd0, 32'h300C, 1'b1);
    chk("sh_be_lit", 32'(last_be), 32'hC);
    chk("sh_wd_lit", last_wd, 32'hBEEFBEEF);
    cyc(1, 4'd2, 32'h2, 32'h0, 5'd3, 32'h3010, 1'b1);
    chk("lh_lit", w_grf_wdata, 32'hFFFFBEEF);
    cyc(1, 4'd3, 32'h2, 32'h0, 5'd3, 32'h3014, 1'b1);
    chk("lhu_lit", w_grf_wdata, 32'h0000BEEF);
    // Word store then load.
    cyc(1, 4'd6, 32'h10, 32'hDEADBEEF, 5'd0, 32'h3000, 1'b1);
    cyc(1, 4'd1, 32'h10, 32'h0, 5'd8, 32'h3004, 1'b1);
    chk("lw_we_lit", 32'(w_grf_we), 32'h1);
    chk("lw_rd_lit", 32'(w_grf_addr), 32'h8);
    chk("lw_wd_lit", w_grf_wdata, 32'hDEADBEEF);
    chk("lw_pc_lit", w_inst_addr, 32'h3004);
    // Faults.
    cyc(1, 4'd6, 32'h3, 32'h55, 5'd0, 32'h3008, 1'b1);
    chk("mis_be_lit", 32'(last_be), 32'h0);
    chk("mis_cnt_lit", 32'(fault_cnt), 32'h1);
    chk("mis_fault_lit", 32'(fault), 32'h1);
    cyc(1, 4'd1, DM_BYTES, 32'h0, 5'd4, 32'h300C, 1'b1);
    chk("oor_cnt_lit", 32'(fault_cnt), 32'h2);
    // ALU result above the memory range is not an access.
    cyc(1, 4'd9, 32'h7FFFFFFF, 32'h0, 5'd31, 32'h3010, 1'b1);
    chk("alu_wd_lit", w_grf_wdata, 32'h7FFFFFFF);
    chk("alu_rd_lit", 32'(w_grf_addr), 32'd31);
    chk("alu_cnt_lit", 32'(fault_cnt), 32'h2);
    // Reset in the middle of a store stream.
    cyc(1, 4'd6, 32'h0, 32'h11111111, 5'd0, 32'h3014, 1'b1);
    cyc(1, 4'd6, 32'h0, 32'h22222222, 5'd0, 32'h3018, 1'b0);
    chk("rst_be_lit", 32'(last_be), 32'h0);
    cyc(1, 4'd6, 32'h0, 32'h33333333, 5'd0, 32'h301C, 1'b0);
    chk("rst_fault_lit", 32'(fault), 32'h0);
    chk("rst_inst_lit", w_inst_addr, 32'h0);
    // Saturation.
    for (int i = 0; i < 300; i++) cyc(1, 4'd1, 32'h2, 32'h0, 5'd1, 32'h4000, 1'b1);
    chk("sat_lit", 32'(fault_cnt), 32'd255);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rr = $urandom;
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) rop = 4'($urandom_range(1, 9));
      case ($urandom_range(0, 3))
        0: ra = rr & 32'h00003FFF;
        1: ra = rr & 32'h00003FFC;
        2: ra = rr;
        default: ra = DM_BYTES - 4 + (rr & 32'h7);
      endcase
      rs = $urandom;
      rp = $urandom;
      cyc(1'($urandom_range(0, 7) != 0), rop, ra, rs, 5'($urandom), rp,
          1'($urandom_range(0, 59) != 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

CPU-side initiator of the data-memory bus and the M→W pipeline boundary of the pipelined MIPS core. It turns a memory-stage request into `m_data_addr`/`m_data_wdata`/`m_data_byteen` and accepts `m_data_rdata` from an asynchronous-read data memory. It then extracts and extends load data and registers the result into the write-back stage. Misaligned and out-of-range accesses are suppressed and counted.

## Interface

Parameters:
- `DM_BYTES`, 16384: data-memory size in bytes; an access with `addr >= DM_BYTES` is out of range.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `m_valid` in 1: M-stage instruction valid; 0 is a bubble.
- `m_op` in 4: 0 NOP, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB, 9 ALU; 10–15 treated as NOP.
- `m_addr` in 32: effective address, or the ALU result when `m_op`=9.
- `m_store` in 32: store source register value.
- `m_rd` in 5: destination register for loads and ALU ops.
- `m_pc` in 32: M-stage instruction address.
- `m_data_addr` out 32: equals `m_addr`.
- `m_data_wdata` out 32: store data replicated into lanes.
- `m_data_byteen` out 4: byte-write enables.
- `m_inst_addr` out 32: equals `m_pc`.
- `m_data_rdata` in 32: read word at `m_data_addr & ~3`, valid in the same cycle.
- `w_grf_we` out 1, `w_grf_addr` out 5, `w_grf_wdata` out 32, `w_inst_addr` out 32: registered write-back.
- `fault` out 1: sticky; set on any suppressed access.
- `fault_cnt` out 8: count of suppressed accesses, saturating at 255.

## Operation

M side (combinational):
- Alignment check: LW/SW need `addr[1:0]`=0. LH/LHU/SH need `addr[0]`=0. Byte ops are always aligned.
- An access is *bad* if it is misaligned or `addr >= DM_BYTES`, and `m_valid`=1 with op 1–8.
- `m_data_byteen`:
  - SW → 4'b1111.
  - SH → 4'b0011 when `addr[1]`=0, 4'b1100 when `addr[1]`=1.
  - SB → `1 << addr[1:0]`.
  - Otherwise 0. Also forced to 0 when bad, when `m_valid`=0, or while `reset`=0.
- `m_data_wdata`:
  - SW → `m_store`.
  - SH → `{2{m_store[15:0]}}`.
  - SB → `{4{m_store[7:0]}}`.
  - Other ops → `m_store`. The value is a don't-care when byteen=0.
- Load extraction from `m_data_rdata`:
  - Select the half by `addr[1]` and the byte by `addr[1:0]`.
  - LH and LB sign-extend; LHU and LBU zero-extend; LW passes the word unchanged.

W register (clocked on posedge):
- `reset`=0 → all `w_*` = 0, `fault`=0, `fault_cnt`=0.
- Otherwise, valid good load or ALU op:
  - `w_grf_we`=1, `w_grf_addr`=`m_rd`, `w_inst_addr`=`m_pc`.
  - `w_grf_wdata` = extracted load value, or `m_addr` for ALU.
- Stores, NOPs, bubbles and bad accesses: `w_grf_we`=0, `w_grf_addr`=0, `w_grf_wdata`=0, `w_inst_addr`=`m_pc`.
- `m_rd`=0 is passed through unchanged; the consumer ignores writes to register 0.
- Bad access: `fault`←1, `fault_cnt`←`fault_cnt`+1 unless already 255.

## Timing

- Store: byteen and wdata are valid in the cycle `m_valid` is high. Memory commits at the next rising edge.
- Load: result appears on `w_grf_*` one cycle after the request (latency 1). No stall and no handshake; one request per cycle.
- Back-to-back store then load to the same word: the load in cycle N+1 sees memory already written at the edge ending cycle N. No internal forwarding is required.
- Reset asserted mid-stream: on the first `reset`=0 edge, W clears. Byteen is 0 during every cycle `reset`=0.
- Reset values: `w_grf_we`=0, `w_grf_addr`=0, `w_grf_wdata`=0, `w_inst_addr`=0, `fault`=0, `fault_cnt`=0.

## Test plan

- SB with `m_addr`=0x00000006, `m_store`=0x123456AB → byteen=4'b0100, wdata=0xABABABAB. Next-cycle LBU at 6 with rdata=0x00AB0000 → W gets wdata=0x000000AB. LB at the same address → 0xFFFFFFAB.
- SH at 0x2, `m_store`=0x0000BEEF → byteen=4'b1100, wdata=0xBEEFBEEF. LH at 0x2 with rdata=0xBEEF0000 → W gets 0xFFFFBEEF; LHU → 0x0000BEEF.
- LW at 0x10, `m_rd`=8, `m_pc`=0x3004, rdata=0xDEADBEEF → next cycle `w_grf_we`=1, addr=8, wdata=0xDEADBEEF, `w_inst_addr`=0x3004.
- SW at 0x3 → byteen=0, W bubble, `fault`=1, `fault_cnt`=1. LW at `DM_BYTES` → `fault_cnt`=2. 300 consecutive bad accesses → counter saturates at 255.
- ALU op, `m_addr`=0x7FFFFFFF, `m_rd`=31 → W write of 0x7FFFFFFF to register 31, no fault and byteen=0 despite the address exceeding `DM_BYTES`.
- Pull `reset` low during a stream of SW at 0x0 → byteen=0 in those cycles. All W outputs and the fault state read 0 after the edge.
